conware_row_feeder: RTL and testbench

Upstream feeder for the Life row array. On a `start` pulse it streams one generation's grid out of a synchronous row memory as a sequence of `HEIGHT+2` rows: an all-zero top pad row, memory rows 0..HEIGHT-1, then an all-zero bottom pad row. The array's `enable`/`in_data` are driven from `row_valid & row_ready` and `row_data`. A small internal FIFO decouples memory read latency from downstream back-pressure.

---
 rtl/conware_row_feeder.sv | 188 ++++++++++++++++++
 tb/tb_conware_row_feeder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conware_row_feeder.sv
// conware_row_feeder
// Streams one Life generation out of a synchronous row memory as HEIGHT+2 rows:
// an all-zero top pad row, memory rows 0..HEIGHT-1, then an all-zero bottom pad
// row. A 4-entry FIFO with credit-based issue decouples the one-cycle memory
// read latency from downstream back-pressure.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   start                 one-cycle frame request, honoured only when idle
//   busy, done            frame in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr   memory read strobe and row address
//   mem_rdata             read data, valid one cycle after mem_rd_en
//   row_data, row_valid   FIFO head towards the row array
//   row_ready             downstream accepts the head row this cycle
//   row_last              head row is the bottom pad row
module conware_row_feeder #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [WIDTH-1:0]  row_data,
    output logic              row_valid,
    input  logic              row_ready,
    output logic              row_last
);

    localparam int SLOT_W = $clog2(HEIGHT + 2);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(HEIGHT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;     // slot issued when issue_q is high
    logic              issue_q, issue_d;   // a slot issues in this cycle
    logic              rd_q, rd_d;         // registered memory strobe
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              v1_q, v1_d;         // slot issued last cycle, push now
    logic              r1_q, r1_d;         // that slot was a memory read
    logic              l1_q, l1_d;         // that slot was the bottom pad

    logic [WIDTH-1:0]  fifo_data_q [4];
    logic [WIDTH-1:0]  fifo_data_d [4];
    logic              fifo_last_q [4];
    logic              fifo_last_d [4];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;

    logic              push_s;
    logic              pop_s;
    logic              slot_is_read_s;

    // Next-state, FIFO and issue logic; the issue decision for the next cycle is
    // made here so the memory strobe and address leave the block from flops.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        push_s = v1_q;
        pop_s  = (count_q != 3'd0) && row_ready;

        if (push_s) begin
            fifo_data_d[wr_ptr_q] = r1_q ? mem_rdata : {WIDTH{1'b0}};
            fifo_last_d[wr_ptr_q] = l1_q;
            wr_ptr_d              = wr_ptr_q + 2'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        count_d = count_q + 3'(push_s) - 3'(pop_s);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    slot_d  = {SLOT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (issue_q) begin
                    if (slot_q == LAST_SLOT) begin
                        state_d = S_DRAIN;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (pop_s && fifo_last_q[rd_ptr_q]) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Credit: next-cycle occupancy plus the slot that will then be in flight.
        issue_d = (state_d == S_FETCH) && ((count_d + 3'(issue_q)) < 3'd4);

        slot_is_read_s = (slot_d != {SLOT_W{1'b0}}) && (slot_d != LAST_SLOT);
        rd_d           = issue_d && slot_is_read_s;
        if (rd_d) begin
            addr_d = ADDR_W'(slot_d - SLOT_W'(1));
        end else begin
            addr_d = addr_q;
        end

        v1_d = issue_q;
        r1_d = rd_q;
        l1_d = issue_q && (slot_q == LAST_SLOT);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            slot_q   <= {SLOT_W{1'b0}};
            issue_q  <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            v1_q     <= 1'b0;
            r1_q     <= 1'b0;
            l1_q     <= 1'b0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= {WIDTH{1'b0}};
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            issue_q     <= issue_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            v1_q        <= v1_d;
            r1_q        <= r1_d;
            l1_q        <= l1_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
        end
    end

    assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign mem_rd_en = rd_q;
    assign mem_addr  = addr_q;
    assign row_valid = (count_q != 3'd0);
    // Head is gated so an empty FIFO never shows stale rows from a prior frame.
    assign row_data  = row_valid ? fifo_data_q[rd_ptr_q] : {WIDTH{1'b0}};
    assign row_last  = row_valid && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_conware_row_feeder.sv
// Testbench for conware_row_feeder: a HEIGHT=4 instance for most scenarios and
// a HEIGHT=1 instance for the single-row corner case.
module tb_conware_row_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       row_ready = 1'b0;
    logic       busy, done, mem_rd_en, row_valid, row_last;
    logic [1:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] row_data;

    logic       start1 = 1'b0;
    logic       ready1 = 1'b0;
    logic       busy1, done1, rd1, valid1, last1;
    logic [0:0] addr1;
    logic [7:0] rdata1 = 8'h00;
    logic [7:0] data1;

    logic [7:0] mem [4];
    logic [7:0] mem1;

    conware_row_feeder #(.WIDTH(8), .HEIGHT(4), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
        .row_last(row_last)
    );

    conware_row_feeder #(.WIDTH(8), .HEIGHT(1), .ADDR_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .mem_rd_en(rd1), .mem_addr(addr1), .mem_rdata(rdata1),
        .row_data(data1), .row_valid(valid1), .row_ready(ready1),
        .row_last(last1)
    );

    // Synchronous memories with one cycle of read latency.
    always_ff @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (rd1) rdata1 <= mem1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       start;
        logic       ready;
        logic       busy;
        logic       done;
        logic       rd_en;
        logic [1:0] addr;
        logic       valid;
        logic [7:0] data;
        logic       last;
    } vec_t;

    vec_t tbl [11];

    // Streams one frame on the HEIGHT=4 instance and checks it against the
    // expected row list {0, mem[0..3], 0}.
    // mode: 0 ready high, 1 ready 1,0,0 pattern, 2 random, 3 ready low for 12 cycles.
    task automatic run_frame(input int mode, input bit extra_starts, output int done_cyc);
        logic [7:0] exp_q [$];
        int idx = 0;
        int reads = 0;
        int memrows = 0;
        int cyc = 0;
        int last_hs = -10;
        int first_valid = -1;
        int rd_cnt [4];
        bit got_done = 1'b0;
        bit stalled = 1'b0;
        logic [7:0] held = 8'h00;
        logic held_last = 1'b0;
        exp_q = '{8'h00, mem[0], mem[1], mem[2], mem[3], 8'h00};
        for (int a = 0; a < 4; a++) rd_cnt[a] = 0;
        done_cyc = -1;
        while (!got_done && cyc < 300) begin
            start = (cyc == 0) ||
                    (extra_starts && (cyc == 2 || cyc == 5 || $urandom_range(0, 7) == 0));
            case (mode)
                0:       row_ready = 1'b1;
                1:       row_ready = ((cyc % 3) == 0);
                2:       row_ready = 1'($urandom_range(0, 1));
                default: row_ready = (cyc >= 12);
            endcase
            @(negedge clk);
            if (mem_rd_en) begin
                reads++;
                rd_cnt[mem_addr]++;
            end
            if (row_valid && first_valid < 0) first_valid = cyc;
            if (stalled) begin
                check("stall_data_stable", row_data, held);
                check("stall_last_stable", row_last, held_last);
            end
            if (row_valid && row_ready) begin
                if (idx < 6) begin
                    check("row_data", row_data, exp_q[idx]);
                    check("row_last", row_last, (idx == 5));
                end else begin
                    check("extra_row", row_valid, 1'b0);
                end
                if (idx >= 1 && idx <= 4) memrows++;
                idx++;
                last_hs = cyc;
            end
            check("outstanding_le4", ((reads - memrows) <= 4), 1'b1);
            if (mode == 3 && cyc == 11) check("credit_stall_reads", reads, 3);
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                check("done_after_last", last_hs, cyc - 1);
                check("rows_in_frame", idx, 6);
                check("busy_in_done", busy, 1'b0);
            end else if (cyc >= 1) begin
                check("busy_in_frame", busy, 1'b1);
            end
            stalled   = row_valid && !row_ready;
            held      = row_data;
            held_last = row_last;
            next_cycle();
            cyc++;
        end
        start = 1'b0;
        if (!got_done) check("done_timeout", got_done, 1'b1);
        check("first_valid_cycle", first_valid, 3);
        for (int a = 0; a < 4; a++) check("reads_per_addr", rd_cnt[a], 1);
    endtask

    task automatic randomize_mem();
        for (int a = 0; a < 4; a++) mem[a] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int dc;
        int hs;
        int c;
        logic [7:0] got1 [$];
        logic       gotl1 [$];
        int rd1_cnt;
        int done1_cyc;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 8'h18, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 8'h24, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 8'h42, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 8'h81, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 8'h00, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 8'h00, 1'b0};

        mem[0] = 8'h18; mem[1] = 8'h24; mem[2] = 8'h42; mem[3] = 8'h81;
        mem1 = 8'hA5;

        // Reset values.
        rst = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_addr", mem_addr, 2'd0);
        check("rst_valid", row_valid, 1'b0);
        check("rst_data", row_data, 8'h00);
        check("rst_last", row_last, 1'b0);
        next_cycle();
        rst = 1'b0;

        // Cycle-exact reference frame.
        for (int i = 0; i < 11; i++) begin
            start     = tbl[i].start;
            row_ready = tbl[i].ready;
            @(negedge clk);
            check("tbl_busy", busy, tbl[i].busy);
            check("tbl_done", done, tbl[i].done);
            check("tbl_rd_en", mem_rd_en, tbl[i].rd_en);
            check("tbl_addr", mem_addr, tbl[i].addr);
            check("tbl_valid", row_valid, tbl[i].valid);
            if (tbl[i].valid) begin
                check("tbl_data", row_data, tbl[i].data);
                check("tbl_last", row_last, tbl[i].last);
            end
            next_cycle();
        end
        start = 1'b0;

        // Back-to-back frames with memory changed in between.
        randomize_mem();
        run_frame(0, 1'b0, dc);
        check("b2b_done_cycle_1", dc, 9);
        randomize_mem();
        run_frame(0, 1'b0, dc);
        check("b2b_done_cycle_2", dc, 9);

        // Back-pressure, ignored starts, credit exhaustion.
        mem[0] = 8'h18; mem[1] = 8'h24; mem[2] = 8'h42; mem[3] = 8'h81;
        run_frame(1, 1'b0, dc);
        run_frame(0, 1'b1, dc);
        check("restart_ignored_done_cycle", dc, 9);
        randomize_mem();
        run_frame(3, 1'b0, dc);

        // Reset in the cycle after the third handshake.
        mem[0] = 8'h18; mem[1] = 8'h24; mem[2] = 8'h42; mem[3] = 8'h81;
        hs = 0;
        c = 0;
        start = 1'b1;
        row_ready = 1'b1;
        while (hs < 3 && c < 20) begin
            @(negedge clk);
            if (row_valid && row_ready) hs++;
            next_cycle();
            start = 1'b0;
            c++;
        end
        check("hs_before_rst", hs, 3);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_rd_en", mem_rd_en, 1'b0);
        check("abort_addr", mem_addr, 2'd0);
        check("abort_valid", row_valid, 1'b0);
        check("abort_data", row_data, 8'h00);
        check("abort_last", row_last, 1'b0);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
            check("abort_no_read", mem_rd_en, 1'b0);
        end
        next_cycle();
        run_frame(0, 1'b0, dc);
        check("post_abort_done_cycle", dc, 9);

        // Single-row grid on the HEIGHT=1 instance.
        rd1_cnt = 0;
        done1_cyc = -1;
        ready1 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            start1 = (k == 0);
            @(negedge clk);
            if (rd1) begin
                rd1_cnt++;
                check("h1_addr", addr1, 1'b0);
            end
            if (valid1 && ready1) begin
                got1.push_back(data1);
                gotl1.push_back(last1);
            end
            if (done1) done1_cyc = k;
            next_cycle();
        end
        start1 = 1'b0;
        check("h1_rows", got1.size(), 3);
        if (got1.size() == 3) begin
            check("h1_row0", got1[0], 8'h00);
            check("h1_row1", got1[1], 8'hA5);
            check("h1_row2", got1[2], 8'h00);
            check("h1_last0", gotl1[0], 1'b0);
            check("h1_last1", gotl1[1], 1'b0);
            check("h1_last2", gotl1[2], 1'b1);
        end
        check("h1_reads", rd1_cnt, 1);
        check("h1_done_cycle", done1_cyc, 6);

        // Randomised frames against the row-list reference.
        for (int f = 0; f < 10; f++) begin
            randomize_mem();
            run_frame(2, 1'($urandom_range(0, 1)), dc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
